// File: rtl/master_slave_sink.sv
// -----------------------------------------------------------------------------
// master_slave_sink
//
// Receiving end of a master/slave link. Samples arriving on the unhandshaked
// s_in/s_in_sync port are summed over a window of DEPTH samples. The window
// sum is then offered on a blocking notify/sync output port. The control is a
// two-section machine: section_a collects samples and section_b emits the sum.
//
// Parameters
//   DEPTH         samples per window, legal range 1..255
//
// Ports
//   clk           clock, all state updates on the rising edge
//   rst           asynchronous active-high reset
//   s_in          [31:0] signed sample from the master
//   s_in_sync     s_in carries a new sample this cycle
//   b_out_sig     [31:0] window sum offered to the consumer (registered)
//   b_out_notify  b_out_sig valid, held until accepted (registered)
//   b_out_sync    consumer ready; transfer when notify && sync
//   drop_cnt      [7:0] saturating count of samples discarded while emitting
//   section_out   current section, 0 = collect, 1 = emit (debug only)
// -----------------------------------------------------------------------------
module master_slave_sink #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] s_in,
  input  logic        s_in_sync,
  output logic [31:0] b_out_sig,
  output logic        b_out_notify,
  input  logic        b_out_sync,
  output logic [7:0]  drop_cnt,
  output logic        section_out
);

  localparam int CW = $clog2(DEPTH + 1);
  // Count value at which the incoming sample is the last one of the window.
  localparam logic [CW-1:0] LAST_CNT = CW'(DEPTH - 1);

  typedef enum logic {
    SECTION_A = 1'b0,  // collect
    SECTION_B = 1'b1   // emit
  } section_t;

  section_t        section_q, section_d;
  logic [31:0]     acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [31:0]     sig_q, sig_d;
  logic            notify_q, notify_d;
  logic [7:0]      drop_q, drop_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      section_q <= SECTION_A;
      acc_q     <= '0;
      cnt_q     <= '0;
      sig_q     <= '0;
      notify_q  <= 1'b0;
      drop_q    <= '0;
    end else begin
      section_q <= section_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      sig_q     <= sig_d;
      notify_q  <= notify_d;
      drop_q    <= drop_d;
    end
  end

  always_comb begin
    section_d = section_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    sig_d     = sig_q;
    notify_d  = notify_q;
    drop_d    = drop_q;

    case (section_q)
      SECTION_A: begin
        // b_out_sync has no meaning while collecting.
        if (s_in_sync) begin
          if (cnt_q == LAST_CNT) begin
            sig_d     = acc_q + s_in;
            notify_d  = 1'b1;
            acc_d     = '0;
            cnt_d     = '0;
            section_d = SECTION_B;
          end else begin
            acc_d = acc_q + s_in;
            cnt_d = cnt_q + CW'(1);
          end
        end
      end

      SECTION_B: begin
        if (b_out_sync) begin
          notify_d  = 1'b0;
          section_d = SECTION_A;
          // A sample arriving on the handshake cycle is kept: it opens the
          // next window. With a one-sample window it is already a complete
          // window, so the output reloads and the emit section is retained.
          if (s_in_sync) begin
            if (LAST_CNT == '0) begin
              sig_d     = s_in;
              notify_d  = 1'b1;
              section_d = SECTION_B;
            end else begin
              acc_d = s_in;
              cnt_d = CW'(1);
            end
          end
        end else if (s_in_sync && (drop_q != 8'hFF)) begin
          drop_d = drop_q + 8'd1;
        end
      end

      default: begin
        section_d = SECTION_A;
      end
    endcase
  end

  assign b_out_sig    = sig_q;
  assign b_out_notify = notify_q;
  assign drop_cnt     = drop_q;
  assign section_out  = (section_q == SECTION_B);

endmodule

// File: tb/tb_master_slave_sink.sv
// -----------------------------------------------------------------------------
// tb_master_slave_sink
//
// Drives a DEPTH=4 and a DEPTH=1 instance of master_slave_sink from the same
// stimulus. A queue-based window model per instance predicts every output
// after every clock edge, and a set of directed checks pins the headline sums.
// -----------------------------------------------------------------------------
module tb_master_slave_sink;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] s_in = '0;
  logic        s_in_sync = 1'b0;
  logic        b_out_sync = 1'b0;

  logic [31:0] sig4, sig1;
  logic        not4, not1;
  logic [7:0]  drop4, drop1;
  logic        sec4, sec1;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  master_slave_sink #(.DEPTH(4)) dut4 (
    .clk(clk), .rst(rst), .s_in(s_in), .s_in_sync(s_in_sync),
    .b_out_sig(sig4), .b_out_notify(not4), .b_out_sync(b_out_sync),
    .drop_cnt(drop4), .section_out(sec4)
  );

  master_slave_sink #(.DEPTH(1)) dut1 (
    .clk(clk), .rst(rst), .s_in(s_in), .s_in_sync(s_in_sync),
    .b_out_sig(sig1), .b_out_notify(not1), .b_out_sync(b_out_sync),
    .drop_cnt(drop1), .section_out(sec1)
  );

  // ---------------- reference model (index 0: DEPTH=4, 1: DEPTH=1) --------
  logic [31:0] win_q [2][$];
  bit          m_busy [2];
  logic [31:0] m_sig  [2];
  int          m_drop [2];
  int          depth_of [2];

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      win_q[i].delete();
      m_busy[i] = 1'b0;
      m_sig[i]  = '0;
      m_drop[i] = 0;
    end
  endtask

  // Add one sample to the open window; a full window becomes the offer.
  task automatic model_feed(input int i, input logic [31:0] d);
    logic [31:0] s;
    s = '0;
    win_q[i].push_back(d);
    if (win_q[i].size() == depth_of[i]) begin
      for (int k = 0; k < win_q[i].size(); k++) s = s + win_q[i][k];
      m_sig[i]  = s;
      m_busy[i] = 1'b1;
      win_q[i].delete();
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      if (!m_busy[i]) begin
        if (s_in_sync) model_feed(i, s_in);
      end else if (b_out_sync) begin
        m_busy[i] = 1'b0;
        if (s_in_sync) model_feed(i, s_in);
      end else if (s_in_sync && m_drop[i] < 255) begin
        m_drop[i]++;
      end
    end
  endtask

  // ---------------- checking ----------------------------------------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("d4_sig",     sig4,             m_sig[0]);
    check("d4_notify",  {31'd0, not4},    {31'd0, m_busy[0]});
    check("d4_drop",    {24'd0, drop4},   32'(m_drop[0]));
    check("d4_section", {31'd0, sec4},    {31'd0, m_busy[0]});
    check("d1_sig",     sig1,             m_sig[1]);
    check("d1_notify",  {31'd0, not1},    {31'd0, m_busy[1]});
    check("d1_drop",    {24'd0, drop1},   32'(m_drop[1]));
    check("d1_section", {31'd0, sec1},    {31'd0, m_busy[1]});
  endtask

  task automatic cycle(input logic sync, input logic [31:0] d, input logic bs);
    @(negedge clk);
    s_in_sync  = sync;
    s_in       = d;
    b_out_sync = bs;
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic do_reset();
    @(negedge clk);
    s_in_sync  = 1'b0;
    b_out_sync = 1'b0;
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------------------------------------
  initial begin
    depth_of[0] = 4;
    depth_of[1] = 1;
    model_reset();

    // Reset, then one window accepted immediately.
    do_reset();
    for (int k = 1; k <= 4; k++) cycle(1'b1, 32'(k), 1'b1);
    check("t1_sum", sig4, 32'd10);
    check("t1_notify_hi", {31'd0, not4}, 32'd1);
    cycle(1'b0, 32'd0, 1'b1);
    check("t1_notify_lo", {31'd0, not4}, 32'd0);
    check("t1_drop", {24'd0, drop4}, 32'd0);

    // Backpressure with samples arriving throughout.
    do_reset();
    for (int k = 1; k <= 4; k++) cycle(1'b1, 32'(k), 1'b0);
    for (int k = 0; k < 5; k++) cycle(1'b1, $urandom, 1'b0);
    cycle(1'b0, 32'd0, 1'b1);
    check("t2_sum", sig4, 32'd10);
    check("t2_drop", {24'd0, drop4}, 32'd5);
    check("t2_section", {31'd0, sec4}, 32'd0);

    // Handshake with a same-cycle sample opening the next window.
    do_reset();
    for (int k = 0; k < 4; k++) cycle(1'b1, 32'd5, 1'b0);
    check("t3_sum1", sig4, 32'd20);
    cycle(1'b1, 32'd7, 1'b1);
    for (int k = 0; k < 3; k++) cycle(1'b1, 32'd1, 1'b0);
    check("t3_sum2", sig4, 32'd10);
    check("t3_drop", {24'd0, drop4}, 32'd0);
    cycle(1'b0, 32'd0, 1'b1);

    // Wrap-around and negative samples.
    do_reset();
    cycle(1'b1, 32'h7FFF_FFFF, 1'b0);
    cycle(1'b1, 32'd1, 1'b0);
    cycle(1'b1, 32'hFFFF_FFFD, 1'b0);
    cycle(1'b1, 32'd0, 1'b0);
    check("t4_wrap", sig4, 32'h7FFF_FFFD);
    cycle(1'b0, 32'd0, 1'b1);
    for (int k = 0; k < 4; k++) cycle(1'b1, 32'hFFFF_FFFF, 1'b0);
    check("t4_neg", sig4, 32'hFFFF_FFFC);
    cycle(1'b0, 32'd0, 1'b1);

    // Drop counter saturation, then back-to-back DEPTH=1 reloads.
    do_reset();
    for (int k = 0; k < 300; k++) cycle(1'b1, $urandom, 1'b0);
    check("t5_sat", {24'd0, drop1}, 32'd255);
    cycle(1'b1, 32'd9, 1'b1);
    check("t5_out9", sig1, 32'd9);
    check("t5_hold", {31'd0, not1}, 32'd1);
    cycle(1'b1, 32'd8, 1'b1);
    check("t5_out8", sig1, 32'd8);
    cycle(1'b0, 32'd0, 1'b1);

    // Asynchronous reset between edges discards a partial window.
    do_reset();
    cycle(1'b1, 32'd1, 1'b0);
    cycle(1'b1, 32'd2, 1'b0);
    @(negedge clk);
    s_in_sync = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    check("t6_sig_rst", sig1, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) cycle(1'b1, 32'd3, 1'b0);
    check("t6_sum", sig4, 32'd12);
    cycle(1'b0, 32'd0, 1'b1);

    // Randomized traffic with occasional resets.
    do_reset();
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
      end else begin
        cycle(1'($urandom_range(0, 1)),
              ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 20)),
              1'($urandom_range(0, 2) != 0));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
